// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver running at 16x baud, feeding a small byte FIFO whose
// head is offered to a faster consumer through a ready/read/ok-toggle handshake.
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 3
) (
  input  logic       clk_uart16,
  input  logic       rst,
  input  logic       rx,
  input  logic       read,
  output logic       ready,
  output logic [7:0] data,
  output logic       ok,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic            rx_meta, rx_s;
  logic            read_meta, read_s;
  logic [2:0]      state;
  logic [3:0]      tcnt;
  logic [2:0]      bcnt;
  logic [7:0]      shreg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]     count, count_next, after_pop;
  logic [HW-1:0]   holdoff;
  logic [7:0]      head_next;
  logic            push, pop, full, push_ok, drop;

  // Two-flop synchronisers for the asynchronous line and the foreign-domain read level
  always_ff @(posedge clk_uart16 or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      read_meta <= 1'b0;
      read_s    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      read_meta <= read;
      read_s    <= read_meta;
    end
  end

  // Frame deserialiser: validate start at mid-bit, then sample every 16 ticks
  always_ff @(posedge clk_uart16 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= 4'd0;
      bcnt      <= 3'd0;
      shreg     <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            tcnt  <= 4'd0;
          end
        end
        S_START: begin
          if (tcnt == 4'd7) begin
            if (!rx_s) begin
              state <= S_DATA;
              tcnt  <= 4'd0;
              bcnt  <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        S_DATA: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            shreg <= {rx_s, shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Push/pop decisions and the next registered head, computed from current state
  always_comb begin
    push        = (state == S_STOP) && (tcnt == 4'd15) && rx_s;
    pop         = read_s && ready && (holdoff == '0);
    full        = (count == FULL_COUNT);
    push_ok     = push && (!full || pop);
    drop        = push && full && !pop;
    rd_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
    after_pop   = pop ? count - COUNT_ONE : count;
    count_next  = push_ok ? after_pop + COUNT_ONE : after_pop;
    head_next   = (after_pop == '0) ? shreg : mem[rd_ptr_next];
  end

  // Storage array, written only when a received byte is accepted
  always_ff @(posedge clk_uart16) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // Pointers, occupancy, registered head view, handshake toggle and holdoff
  always_ff @(posedge clk_uart16 or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b0;
      data     <= 8'd0;
      ok       <= 1'b0;
      overflow <= 1'b0;
      holdoff  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      ready  <= (count_next != '0);
      if (count_next != '0) data <= head_next;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        ok      <= ~ok;
        holdoff <= HOLD_LOAD;
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HOLD_ONE;
      end
    end
  end

endmodule
